// File: rtl/lut_neuron_prog_if.sv
// lut_neuron_prog_if
// Purpose: bundles the lookup handshake, result handshake and table
//   configuration port of one programmable truth-table neuron.
// Parameters: ADDR_W   - table address width (fan-in * bits per input)
//             OUT_BITS - output activation width
// Signals:
//   in_valid/in_ready/in_data     lookup request (in_data is the address)
//   out_valid/out_ready/out_data  lookup result
//   cfg_we/cfg_addr/cfg_data      table write port, cfg_ready when honoured
//   init_done                     post-reset clear sweep has finished
// Modports: master drives requests/config, slave is the neuron.
interface lut_neuron_prog_if #(
  parameter int ADDR_W   = 6,
  parameter int OUT_BITS = 2
) ();
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_ready;
  logic                init_done;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, init_done
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, init_done
  );
endinterface

// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog
// Purpose: runtime-programmable truth-table neuron. The concatenated input
//   activations address a DEPTH x OUT_BITS table; the result is returned one
//   cycle after acceptance over a ready/valid handshake. After reset the
//   table is swept to INIT_VAL, then a configuration port may rewrite it.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-low reset
//   bus - lut_neuron_prog_if slave (lookup, result, config, init_done)
module lut_neuron_prog #(
  parameter int                  FAN_IN   = 3,
  parameter int                  IN_BITS  = 2,
  parameter int                  OUT_BITS = 2,
  parameter logic [OUT_BITS-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  lut_neuron_prog_if.slave bus
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_ptr_reg;
  logic                out_valid_reg;
  logic [OUT_BITS-1:0] out_data_reg;
  logic                init_done_reg;

  // Table storage; deliberately not reset, the clear sweep initialises it.
  logic [OUT_BITS-1:0] table_mem [DEPTH];

  logic                in_ready;
  logic                accept;
  logic                tbl_we;
  logic [ADDR_W-1:0]   tbl_waddr;
  logic [OUT_BITS-1:0] tbl_wdata;

  // A config write steals the cycle so a write and a lookup never share an edge.
  assign in_ready = (state_reg == RUN) && !bus.cfg_we && (!out_valid_reg || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single table write port, shared by the clear sweep and the config port.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = bus.cfg_addr;
    tbl_wdata = bus.cfg_data;
    if (rst) begin
      if (state_reg == CLEAR) begin
        tbl_we    = 1'b1;
        tbl_waddr = clr_ptr_reg;
        tbl_wdata = INIT_VAL;
      end else if (bus.cfg_we) begin
        tbl_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_mem[tbl_waddr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= CLEAR;
      clr_ptr_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      init_done_reg <= 1'b0;
    end else if (state_reg == CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + 1'b1;
      // All-ones pointer means this edge writes the last entry.
      if (&clr_ptr_reg) begin
        state_reg     <= RUN;
        init_done_reg <= 1'b1;
      end
    end else begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= table_mem[bus.in_data];
      end else if (bus.out_ready) begin
        // Result consumed; out_data keeps its last value.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.cfg_ready = (state_reg == RUN);
  assign bus.init_done = init_done_reg;
endmodule
